// File: rtl/data_axi_arbiter_pkg.sv
// Shared types and helpers for the data_axi requester arbiter.
// Build option: DATA_AXI_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin arbitration.
package data_axi_arbiter_pkg;

    localparam int unsigned DAX_ARB_MAX_PORTS = 8;

    // Request kind presented by the requesters and forwarded to data_axi.
    typedef enum logic {
        SINGLE_REQ     = 1'b0,
        CACHE_LINE_REQ = 1'b1
    } req_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB_HOLD = 2'd1,
        WAIT_RSP = 2'd2
    } dax_arb_state_t;

    // (base + off) modulo n, valid for base < n and off <= n.
    function automatic int unsigned dax_arb_wrap_add(input int unsigned base,
                                                     input int unsigned off,
                                                     input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/data_axi_rr_pick.sv
// Combinational rotating-priority picker: first set request searching upward
// from ptr_i, wrapping modulo NR_PORTS. Tie ptr_i to 0 for fixed priority.
// Ports: req_i request vector, ptr_i search start,
//        gnt_o one-hot winner, idx_o winner index, valid_o any request present.
module data_axi_rr_pick
    import data_axi_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS = 3,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    // Walk the ports starting at ptr_i; the first hit wins.
    always_comb begin : pick
        int unsigned cand;
        cand    = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            cand = dax_arb_wrap_add(32'(ptr_i), i, NR_PORTS);
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o               = 1'b1;
                idx_o                 = IDX_W'(cand);
                gnt_o[IDX_W'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_axi_arbiter.sv
// Shares one single-outstanding data_axi adapter between NR_PORTS requesters.
// The winner is locked from arbitration until its response returns; its request
// fields stay muxed onto the dax_* bus for the whole transaction.
// Build option: DATA_AXI_ARB_FIXED_PRIO_EN -> fixed priority (port 0 highest),
// otherwise round-robin starting after the last completed owner.
// Ports: clk_i/rst_i (sync, active-high); per-port req_i/type_i/addr_i/we_i/
//        wdata_i/be_i/size_i in, gnt_o/valid_o/critical_word_valid_o one-hot out;
//        rdata_o/critical_word_o broadcast; err_o sticky protocol error;
//        dax_* request fields out to data_axi and response fields in from it.
module data_axi_arbiter
    import data_axi_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AXI_ID_WIDTH = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NR_PORTS-1:0]                          req_i,
    input  req_t [NR_PORTS-1:0]                          type_i,
    input  logic [NR_PORTS-1:0][33:0]                    addr_i,
    input  logic [NR_PORTS-1:0]                          we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/32-1:0][31:0] wdata_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/32-1:0][3:0]  be_i,
    input  logic [NR_PORTS-1:0][1:0]                     size_i,
    output logic [NR_PORTS-1:0]                          gnt_o,
    output logic [NR_PORTS-1:0]                          valid_o,
    output logic [DATA_WIDTH/32-1:0][31:0]               rdata_o,
    output logic [31:0]                                  critical_word_o,
    output logic [NR_PORTS-1:0]                          critical_word_valid_o,
    output logic                                         err_o,
    output logic                                         dax_req_o,
    output req_t                                         dax_type_o,
    output logic [33:0]                                  dax_addr_o,
    output logic                                         dax_we_o,
    output logic [DATA_WIDTH/32-1:0][31:0]               dax_wdata_o,
    output logic [DATA_WIDTH/32-1:0][3:0]                dax_be_o,
    output logic [1:0]                                   dax_size_o,
    output logic [AXI_ID_WIDTH-1:0]                      dax_id_o,
    input  logic                                         dax_gnt_i,
    input  logic [AXI_ID_WIDTH-1:0]                      dax_gnt_id_i,
    input  logic                                         dax_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]                      dax_id_i,
    input  logic [DATA_WIDTH/32-1:0][31:0]               dax_rdata_i,
    input  logic [31:0]                                  dax_critical_word_i,
    input  logic                                         dax_critical_word_valid_i
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    dax_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    pick_ptr;
    logic [NR_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    sel;

`ifdef DATA_AXI_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`endif

    data_axi_rr_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            err_q    <= 1'b0;
`ifndef DATA_AXI_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
`ifndef DATA_AXI_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Next state, lock owner, sticky protocol error and round-robin pointer.
    always_comb begin : next_state
        state_d  = state_q;
        owner_d  = owner_q;
        err_d    = err_q;
`ifndef DATA_AXI_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    if (dax_gnt_i) begin
                        state_d = WAIT_RSP;
                        if (dax_gnt_id_i != AXI_ID_WIDTH'(pick_idx)) err_d = 1'b1;
                    end else begin
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                // The owner must keep requesting until granted.
                if (!req_i[owner_q]) err_d = 1'b1;
                if (dax_gnt_i) begin
                    state_d = WAIT_RSP;
                    if (dax_gnt_id_i != AXI_ID_WIDTH'(owner_q)) err_d = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (dax_valid_i) begin
                    if (dax_id_i == AXI_ID_WIDTH'(owner_q)) begin
                        state_d  = IDLE;
`ifndef DATA_AXI_ARB_FIXED_PRIO_EN
                        rr_ptr_d = IDX_W'(dax_arb_wrap_add(32'(owner_q), 1, NR_PORTS));
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; everything reads as zero while reset is asserted.
    always_comb begin : outputs
        sel                   = owner_q;
        gnt_o                 = '0;
        valid_o               = '0;
        critical_word_valid_o = '0;
        rdata_o               = '0;
        critical_word_o       = '0;
        err_o                 = 1'b0;
        dax_req_o             = 1'b0;
        dax_type_o            = SINGLE_REQ;
        dax_addr_o            = '0;
        dax_we_o              = 1'b0;
        dax_wdata_o           = '0;
        dax_be_o              = '0;
        dax_size_o            = '0;
        dax_id_o              = '0;
        if (!rst_i) begin
            err_o           = err_q;
            rdata_o         = dax_rdata_i;
            critical_word_o = dax_critical_word_i;
            // Only IDLE follows the picker; afterwards the mux is pinned to the
            // owner because data_axi keeps reading wdata/be after the grant.
            if (state_q == IDLE) sel = pick_idx;
            dax_type_o  = type_i[sel];
            dax_addr_o  = addr_i[sel];
            dax_we_o    = we_i[sel];
            dax_wdata_o = wdata_i[sel];
            dax_be_o    = be_i[sel];
            dax_size_o  = size_i[sel];
            dax_id_o    = AXI_ID_WIDTH'(sel);
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        dax_req_o = 1'b1;
                        if (dax_gnt_i) gnt_o = pick_gnt;
                    end
                end
                ARB_HOLD: begin
                    dax_req_o = 1'b1;
                    if (dax_gnt_i) gnt_o[owner_q] = 1'b1;
                end
                WAIT_RSP: begin
                    critical_word_valid_o[owner_q] = dax_critical_word_valid_i;
                    if (dax_valid_i && (dax_id_i == AXI_ID_WIDTH'(owner_q))) begin
                        valid_o[owner_q] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_axi_arbiter.sv
// Self-checking bench for data_axi_arbiter: the bench plays data_axi and the
// requesters, and predicts winners from a plain rotating-search model.
module tb_data_axi_arbiter;
    import data_axi_arbiter_pkg::*;

    localparam int unsigned NP  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = 4;
    localparam int unsigned NW  = DW / 32;
    localparam int unsigned IW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rst;
    logic [NP-1:0]                 req;
    req_t [NP-1:0]                 typ;
    logic [NP-1:0][33:0]           addr;
    logic [NP-1:0]                 we;
    logic [NP-1:0][NW-1:0][31:0]   wdata;
    logic [NP-1:0][NW-1:0][3:0]    be;
    logic [NP-1:0][1:0]            size;
    logic [NP-1:0]                 gnt, valid, cwv;
    logic [NW-1:0][31:0]           rdata;
    logic [31:0]                   cw;
    logic                          err;
    logic                          dreq;
    req_t                          dtype;
    logic [33:0]                   daddr;
    logic                          dwe;
    logic [NW-1:0][31:0]           dwdata;
    logic [NW-1:0][3:0]            dbe;
    logic [1:0]                    dsize;
    logic [IDW-1:0]                did;
    logic                          dgnt;
    logic [IDW-1:0]                dgnt_id;
    logic                          dvalid;
    logic [IDW-1:0]                dvid;
    logic [NW-1:0][31:0]           drdata;
    logic [31:0]                   dcw;
    logic                          dcwv;

    int n_tests;
    int n_fail;
    int exp_ptr;

    data_axi_arbiter #(
        .NR_PORTS     (NP),
        .DATA_WIDTH   (DW),
        .AXI_ID_WIDTH (IDW)
    ) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .req_i                     (req),
        .type_i                    (typ),
        .addr_i                    (addr),
        .we_i                      (we),
        .wdata_i                   (wdata),
        .be_i                      (be),
        .size_i                    (size),
        .gnt_o                     (gnt),
        .valid_o                   (valid),
        .rdata_o                   (rdata),
        .critical_word_o           (cw),
        .critical_word_valid_o     (cwv),
        .err_o                     (err),
        .dax_req_o                 (dreq),
        .dax_type_o                (dtype),
        .dax_addr_o                (daddr),
        .dax_we_o                  (dwe),
        .dax_wdata_o               (dwdata),
        .dax_be_o                  (dbe),
        .dax_size_o                (dsize),
        .dax_id_o                  (did),
        .dax_gnt_i                 (dgnt),
        .dax_gnt_id_i              (dgnt_id),
        .dax_valid_i               (dvalid),
        .dax_id_i                  (dvid),
        .dax_rdata_i               (drdata),
        .dax_critical_word_i       (dcw),
        .dax_critical_word_valid_i (dcwv)
    );

    // Reference: first requesting port at or after the start point, wrapping.
    function automatic int model_winner(input logic [NP-1:0] r, input int ptr);
        int start;
        start = ptr;
`ifdef DATA_AXI_ARB_FIXED_PRIO_EN
        start = 0;
`endif
        for (int i = 0; i < NP; i++) begin
            if (r[IW'((start + i) % NP)]) return (start + i) % NP;
        end
        return -1;
    endfunction

    task automatic clr_dax();
        dgnt = 1'b0; dgnt_id = '0; dvalid = 1'b0; dvid = '0;
        drdata = '0; dcw = '0; dcwv = 1'b0;
    endtask

    task automatic rand_fields();
        for (int p = 0; p < NP; p++) begin
            typ[p]   = req_t'(1'($urandom_range(0, 1)));
            addr[p]  = {2'b00, 32'($urandom())};
            we[p]    = 1'($urandom_range(0, 1));
            wdata[p] = 32'($urandom());
            be[p]    = 4'($urandom());
            size[p]  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; req = '0; clr_dax();
        @(negedge clk); rst = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; req = '1; clr_dax(); dgnt = 1'b1; dvalid = 1'b1; dcwv = 1'b1;
        drdata = 32'hdead_beef; #1;
        n_tests++; if ({gnt, valid, cwv} !== '0) begin n_fail++; $display("FAIL reset_onehots: got %b want 0", {gnt, valid, cwv}); end
        n_tests++; if ({dreq, err} !== 2'b00) begin n_fail++; $display("FAIL reset_req_err: got %b want 00", {dreq, err}); end
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        @(negedge clk); rst = 1'b0; req = '0; clr_dax(); #1;
        n_tests++; if ({dreq, err, gnt} !== '0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", {dreq, err, gnt}); end
        exp_ptr = 0;
    endtask

    // Randomised traffic with random grant/response latency.
    task automatic test_round_robin();
        int k, d, r;
        logic [NP-1:0] rq, oh;
        logic [31:0] rw, cwd;
        for (int it = 0; it < 12; it++) begin
            rq = (it < 4) ? '1 : NP'($urandom_range(1, 7));
            d  = $urandom_range(0, 2);
            r  = $urandom_range(0, 2);
            rw = $urandom(); cwd = $urandom();
            k  = model_winner(rq, exp_ptr);
            oh = NP'(1) << k;
            @(negedge clk); clr_dax(); rand_fields(); req = rq;
            dgnt = (d == 0); dgnt_id = IDW'(k); #1;
            n_tests++;
            if (dreq !== 1'b1 || did !== IDW'(k) || daddr !== addr[k] || dwdata !== wdata[k] || dbe !== be[k]) begin
                n_fail++; $display("FAIL rr_fwd it%0d: got req=%b id=%0d addr=%h want req=1 id=%0d addr=%h", it, dreq, did, daddr, k, addr[k]);
            end
            n_tests++; if (gnt !== ((d == 0) ? oh : '0)) begin n_fail++; $display("FAIL rr_gnt0 it%0d: got %b want %b", it, gnt, (d == 0) ? oh : '0); end
            for (int j = 1; j <= d; j++) begin
                @(negedge clk); dgnt = (j == d); #1;
                n_tests++;
                if (dreq !== 1'b1 || did !== IDW'(k) || gnt !== ((j == d) ? oh : '0)) begin
                    n_fail++; $display("FAIL rr_hold it%0d: got req=%b id=%0d gnt=%b want req=1 id=%0d", it, dreq, did, gnt, k);
                end
            end
            for (int j = 0; j < r; j++) begin
                @(negedge clk); clr_dax(); #1;
                n_tests++; if ({dreq, gnt, valid} !== '0) begin n_fail++; $display("FAIL rr_wait it%0d: got %b want 0", it, {dreq, gnt, valid}); end
            end
            @(negedge clk); clr_dax(); dvalid = 1'b1; dvid = IDW'(k); drdata = rw; dcw = cwd; dcwv = 1'b1; #1;
            n_tests++;
            if (valid !== oh || rdata !== rw || cwv !== oh || cw !== cwd) begin
                n_fail++; $display("FAIL rr_rsp it%0d: got valid=%b rdata=%h cwv=%b want valid=%b rdata=%h", it, valid, rdata, cwv, oh, rw);
            end
            exp_ptr = (k + 1) % NP;
        end
        @(negedge clk); clr_dax(); req = '0; #1;
        n_tests++; if (valid !== '0) begin n_fail++; $display("FAIL rr_valid_pulse: got %b want 0", valid); end
    endtask

    task automatic test_single_read();
        logic [31:0] w;
        w = $urandom();
        @(negedge clk); clr_dax(); req = 3'b010; addr[1] = 34'h0_0000_1004; typ[1] = SINGLE_REQ; we[1] = 1'b0;
        dgnt = 1'b1; dgnt_id = 4'd1; #1;
        n_tests++; if (gnt !== 3'b010 || did !== 4'd1 || daddr !== 34'h0_0000_1004 || dtype !== SINGLE_REQ) begin
            n_fail++; $display("FAIL single_req: got gnt=%b id=%0d addr=%h want gnt=010 id=1 addr=1004", gnt, did, daddr);
        end
        @(negedge clk); clr_dax(); req = '0; #1;
        n_tests++; if ({dreq, gnt} !== '0) begin n_fail++; $display("FAIL single_wait: got %b want 0", {dreq, gnt}); end
        @(negedge clk); dvalid = 1'b1; dvid = 4'd1; drdata = w; #1;
        n_tests++; if (valid !== 3'b010 || rdata !== w) begin n_fail++; $display("FAIL single_rsp: got valid=%b rdata=%h want 010 %h", valid, rdata, w); end
        @(negedge clk); clr_dax(); #1;
        n_tests++; if (valid !== '0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", valid); end
        exp_ptr = 2;
    endtask

    // Port 2 line write with a late grant while port 0 waits for its turn.
    task automatic test_hold_delay();
        logic [31:0] w;
        w = $urandom();
        @(negedge clk); clr_dax(); req = 3'b100; typ[2] = CACHE_LINE_REQ; we[2] = 1'b1; wdata[2] = w; be[2] = 4'hf; #1;
        n_tests++; if (did !== 4'd2 || dreq !== 1'b1 || gnt !== '0) begin n_fail++; $display("FAIL hold_first: got id=%0d req=%b gnt=%b want 2 1 000", did, dreq, gnt); end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); req = 3'b101; #1;
            n_tests++; if (did !== 4'd2 || dwdata !== w || dreq !== 1'b1 || gnt !== '0) begin
                n_fail++; $display("FAIL hold_locked: got id=%0d wdata=%h gnt=%b want 2 %h 000", did, dwdata, gnt, w);
            end
        end
        @(negedge clk); dgnt = 1'b1; dgnt_id = 4'd2; #1;
        n_tests++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL hold_gnt: got %b want 100", gnt); end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); clr_dax(); #1;
            n_tests++; if (dreq !== 1'b0 || dwdata !== w || did !== 4'd2 || gnt !== '0) begin
                n_fail++; $display("FAIL hold_wait: got req=%b wdata=%h id=%0d want 0 %h 2", dreq, dwdata, did, w);
            end
        end
        @(negedge clk); dvalid = 1'b1; dvid = 4'd2; #1;
        n_tests++; if (valid !== 3'b100) begin n_fail++; $display("FAIL hold_rsp: got %b want 100", valid); end
        exp_ptr = 0;
        @(negedge clk); clr_dax(); dgnt = 1'b1; dgnt_id = 4'd0; #1;
        n_tests++; if (did !== IDW'(model_winner(3'b001, exp_ptr)) || gnt !== 3'b001 || valid !== '0) begin
            n_fail++; $display("FAIL hold_next: got id=%0d gnt=%b valid=%b want 0 001 000", did, gnt, valid);
        end
        @(negedge clk); clr_dax(); req = '0; dvalid = 1'b1; dvid = 4'd0; #1;
        n_tests++; if (valid !== 3'b001) begin n_fail++; $display("FAIL hold_next_rsp: got %b want 001", valid); end
        exp_ptr = 1;
    endtask

    // Ports 0 and 2 request continuously; model decides who wins each time.
    task automatic test_two_port_prio();
        int k;
        logic [NP-1:0] oh;
        for (int it = 0; it < 4; it++) begin
            k = model_winner(3'b101, exp_ptr);
            oh = NP'(1) << k;
            @(negedge clk); clr_dax(); req = 3'b101; dgnt = 1'b1; dgnt_id = IDW'(k); #1;
            n_tests++; if (did !== IDW'(k) || gnt !== oh) begin n_fail++; $display("FAIL prio_win it%0d: got id=%0d gnt=%b want %0d %b", it, did, gnt, k, oh); end
            @(negedge clk); clr_dax(); dvalid = 1'b1; dvid = IDW'(k); #1;
            n_tests++; if (valid !== oh) begin n_fail++; $display("FAIL prio_rsp it%0d: got %b want %b", it, valid, oh); end
            exp_ptr = (k + 1) % NP;
        end
        @(negedge clk); clr_dax(); req = '0;
    endtask

    task automatic test_drop_err();
        @(negedge clk); clr_dax(); req = 3'b001; #1;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_pre: got err=%b want 0", err); end
        @(negedge clk); req = '0; #1;
        n_tests++; if (dreq !== 1'b1 || did !== 4'd0 || err !== 1'b0) begin n_fail++; $display("FAIL drop_same: got req=%b id=%0d err=%b want 1 0 0", dreq, did, err); end
        @(negedge clk); #1;
        n_tests++; if (err !== 1'b1 || dreq !== 1'b1) begin n_fail++; $display("FAIL drop_err: got err=%b req=%b want 1 1", err, dreq); end
        @(negedge clk); dgnt = 1'b1; dgnt_id = 4'd0; #1;
        n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL drop_gnt: got %b want 001", gnt); end
        @(negedge clk); clr_dax(); dvalid = 1'b1; dvid = 4'd0; #1;
        n_tests++; if (valid !== 3'b001 || err !== 1'b1) begin n_fail++; $display("FAIL drop_rsp: got valid=%b err=%b want 001 1", valid, err); end
        do_reset();
        #1;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_bad_id();
        logic [31:0] w;
        w = $urandom();
        @(negedge clk); clr_dax(); req = 3'b010; dgnt = 1'b1; dgnt_id = 4'd1; #1;
        n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL badid_gnt: got %b want 010", gnt); end
        @(negedge clk); clr_dax(); req = '0; dvalid = 1'b1; dvid = 4'd2; #1;
        n_tests++; if (valid !== '0) begin n_fail++; $display("FAIL badid_ignored: got %b want 000", valid); end
        @(negedge clk); clr_dax(); #1;
        n_tests++; if (err !== 1'b1 || valid !== '0) begin n_fail++; $display("FAIL badid_err: got err=%b valid=%b want 1 000", err, valid); end
        @(negedge clk); dvalid = 1'b1; dvid = 4'd1; drdata = w; #1;
        n_tests++; if (valid !== 3'b010 || rdata !== w) begin n_fail++; $display("FAIL badid_good: got valid=%b rdata=%h want 010 %h", valid, rdata, w); end
        @(negedge clk); clr_dax(); #1;
        n_tests++; if ({valid, dreq} !== '0) begin n_fail++; $display("FAIL badid_idle: got %b want 0", {valid, dreq}); end
        do_reset();
    endtask

    // Reset while waiting for a response abandons it; pointer returns to 0.
    task automatic test_reset_mid();
        int k;
        @(negedge clk); clr_dax(); req = 3'b010; dgnt = 1'b1; dgnt_id = 4'd1;
        @(negedge clk); clr_dax(); req = '0; dvalid = 1'b1; dvid = 4'd1;
        @(negedge clk); clr_dax(); req = 3'b100; dgnt = 1'b1; dgnt_id = 4'd2; #1;
        n_tests++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 100", gnt); end
        @(negedge clk); clr_dax(); req = '0; rst = 1'b1; dvalid = 1'b1; dvid = 4'd2; dcwv = 1'b1; drdata = 32'h1234_5678; #1;
        n_tests++; if ({valid, gnt, cwv, dreq, err} !== '0 || rdata !== '0) begin
            n_fail++; $display("FAIL rstmid_quiet: got valid=%b gnt=%b cwv=%b req=%b rdata=%h want 0", valid, gnt, cwv, dreq, rdata);
        end
        exp_ptr = 0;
        k = model_winner(3'b111, exp_ptr);
        @(negedge clk); clr_dax(); rst = 1'b0; req = 3'b111; dgnt = 1'b1; dgnt_id = IDW'(k); #1;
        n_tests++; if (did !== IDW'(k) || dreq !== 1'b1 || gnt !== (NP'(1) << k)) begin
            n_fail++; $display("FAIL rstmid_rearb: got id=%0d req=%b gnt=%b want %0d 1", did, dreq, gnt, k);
        end
        @(negedge clk); clr_dax(); req = '0; dvalid = 1'b1; dvid = IDW'(k); #1;
        n_tests++; if (valid !== (NP'(1) << k)) begin n_fail++; $display("FAIL rstmid_rsp: got %b want onehot %0d", valid, k); end
        @(negedge clk); clr_dax();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_ptr = 0;
        rst = 1'b1; req = '0; typ = '{default: SINGLE_REQ}; addr = '0; we = '0;
        wdata = '0; be = '0; size = '0;
        clr_dax();
        test_reset();
        test_round_robin();
        test_single_read();
        test_hold_delay();
        test_two_port_prio();
        test_drop_err();
        test_bad_id();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_axi_arbiter.md
Name: data_axi_arbiter

Overview:
- Shares one data_axi adapter, which runs one transaction at a time, between NR_PORTS requesters: dcache miss/refill, dcache writeback and uncached/MMIO.
- Round-robin arbitration. The winner is locked until its response (valid) returns, then the winner's response is routed back to it.
- Sits between the LSU/dcache requesters and data_axi, in the same clock domain.

Parameters:
- NR_PORTS, 3, number of requesters (2..8).
- DATA_WIDTH, 32, cache-line width; must match data_axi.
- AXI_ID_WIDTH, 4, must satisfy 2**AXI_ID_WIDTH >= NR_PORTS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  [NR_PORTS]  per-port request.
- type_i  in  [NR_PORTS] req_t  SINGLE_REQ / cache-line request.
- addr_i  in  [NR_PORTS][33:0]  byte address.
- we_i  in  [NR_PORTS]  write enable.
- wdata_i  in  [NR_PORTS][DATA_WIDTH/32][31:0]  write line.
- be_i  in  [NR_PORTS][DATA_WIDTH/32][3:0]  byte enables.
- size_i  in  [NR_PORTS][1:0]  AXI size.
- gnt_o  out  [NR_PORTS]  one-hot grant.
- valid_o  out  [NR_PORTS]  one-hot completion.
- rdata_o  out  [DATA_WIDTH/32][31:0]  read line, broadcast.
- critical_word_o  out  32  broadcast.
- critical_word_valid_o  out  [NR_PORTS]  one-hot.
- err_o  out  1  sticky protocol-error flag.
- dax_req_o, dax_type_o, dax_addr_o, dax_we_o, dax_wdata_o, dax_be_o, dax_size_o, dax_id_o  out  request fields to data_axi.
- dax_gnt_i, dax_gnt_id_i, dax_valid_i, dax_id_i, dax_rdata_i, dax_critical_word_i, dax_critical_word_valid_i  in  response fields from data_axi.

Behaviour:
- **Reset (rst_i=1 at posedge):**
  - state=IDLE, rr_ptr=0, owner=0, err_o=0.
  - While rst_i is high, all outputs are forced to 0, including dax_req_o.
  - data_axi must be reset in the same cycle. Reset mid-transaction abandons it with no valid_o.
- **State machine: IDLE, ARB_HOLD, WAIT_RSP.**
- **IDLE:**
  - The winner is the first set req_i[k] searching from rr_ptr upward, wrapping modulo NR_PORTS.
  - The winner's fields are forwarded combinationally, with dax_req_o=1 and dax_id_o=k zero-extended. This gives zero-cycle request latency.
  - If dax_gnt_i is high in the same cycle: gnt_o[k]=1, go to WAIT_RSP. Otherwise go to ARB_HOLD.
  - In both cases owner<=k.
- **ARB_HOLD:**
  - Forward port owner only; no re-arbitration.
  - On dax_gnt_i: gnt_o[owner]=1, go to WAIT_RSP.
  - The requester must hold req and all fields stable until gnt. Deassertion before gnt sets err_o; the arbiter keeps forwarding with dax_req_o=1.
- **WAIT_RSP:**
  - The mux stays on owner, because data_axi reads wdata_i/be_i after gnt is issued.
  - dax_req_o=0.
  - dax_critical_word_valid_i is routed to critical_word_valid_o[owner].
  - On dax_valid_i with dax_id_i==owner: valid_o[owner]=1 for exactly one cycle, rdata_o=dax_rdata_i, rr_ptr<=owner+1 (wrapping), state=IDLE.
  - dax_valid_i with a mismatched id sets err_o and is otherwise ignored.
- **Fairness and throughput:**
  - Simultaneous requests on all ports with rr_ptr=0 are granted in order 0,1,2,0...
  - A new arbitration occurs in the cycle after valid_o. There is no back-to-back overlap, because data_axi returns to IDLE after its valid.
- **Other rules:**
  - Non-owner ports see gnt_o=0, valid_o=0 and critical_word_valid_o=0 at all times.
  - dax_gnt_id_i is checked against owner; a mismatch sets err_o.
  - err_o clears only on reset.

Optional Feature:
- Macro DATA_AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not instantiated and the search always starts at port 0.
- Undefined: round-robin as above.
- Lock, routing and error behaviour are identical in both modes.

Decomposition:
- riscv_package: reuse req_t. Add the localparam DAX_ARB_MAX_PORTS=8 and a typedef enum logic[1:0] dax_arb_state_t.
- One sub-module: data_axi_rr_pick (combinational; req vector + ptr -> one-hot grant + index). It is also reused for the fixed-priority mode with ptr tied to 0.

Test Plan:
- Single read on port 1, addr=0x0000_1004, type SINGLE_REQ, dax_gnt_i in the same cycle -> gnt_o=3'b010 that cycle, dax_id_o=1, later valid_o=3'b010 with rdata_o equal to the returned word.
- All three ports request reads continuously -> grant order 0,1,2,0; each valid_o one-hot to the correct port; no overlap between transactions.
- Cache-line write on port 2 with dax_gnt_i delayed 3 cycles; port 0 requests meanwhile -> port 0 is not forwarded until port 2's valid; dax_wdata_o stays on port 2's line throughout.
- Port 0 drops req_i in ARB_HOLD -> err_o=1 next cycle; dax_req_o stays 1 until gnt.
- dax_valid_i with dax_id_i=2 while owner=1 -> err_o=1, no valid_o; the correct id=1 response later completes normally.
- rst_i asserted in WAIT_RSP -> next cycle state IDLE, all outputs 0, rr_ptr=0. With DATA_AXI_ARB_FIXED_PRIO_EN, constant requests on ports 0 and 2 -> port 0 always wins.
